shift_link_rx: RTL and testbench

Receive-side model of the display serial link: it accepts the 74HC595-style `sclk`/`rclk`/`_srclr`/`serial_data` stream produced by the frame-buffer drivers and deserializes it into latched 16-bit words. It decodes each word into an 8-row segment image. The block oversamples all link pins in the system clock domain. It serves as an in-fabric checker for display drivers and as the input stage when a second board consumes display traffic.

---
 rtl/shift_link_pkg.sv | 29 ++
 rtl/link_sync_edge.sv | 31 +++
 rtl/shift_link_rx.sv | 120 ++++++++++++
 tb/tb_shift_link_rx.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/shift_link_pkg.sv
// Shared constants and helpers for the display-link receiver.
// Word layout: upper byte selects rows (active-low), lower byte is segment data.
package shift_link_pkg;

    localparam int LINK_WIDTH = 16;
    localparam int ROWS       = 8;
    localparam int CNT_W      = 5;

    localparam int SEL_MSB = 15;
    localparam int SEL_LSB = 8;
    localparam int SEG_MSB = 7;
    localparam int SEG_LSB = 0;

    // Returns {valid, idx}: valid only when exactly one bit of sel is 0, idx is its position.
    function automatic logic [3:0] zero_index(input logic [7:0] sel);
        logic [2:0] idx;
        logic [3:0] zeros;
        idx   = 3'd0;
        zeros = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (!sel[i]) begin
                zeros = zeros + 4'd1;
                idx   = i[2:0];
            end
        end
        return {(zeros == 4'd1), idx};
    endfunction

endpackage

// File: rtl/link_sync_edge.sv
// Multi-stage synchronizer for one link pin plus a history flop for edge detection.
module link_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
            hist_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-1] & ~hist_q;
    assign fall  = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/shift_link_rx.sv
// Receive side of the 595-style display link: deserializes, latches and decodes
// each word into an 8-row segment image, all sampled in the clk domain.
module shift_link_rx
    import shift_link_pkg::*;
#(
    parameter int WIDTH       = LINK_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sclk_in,
    input  logic               rclk_in,
    input  logic               srclr_n_in,
    input  logic               serial_in,
    output logic [WIDTH-1:0]   word,
    output logic               word_valid,
    output logic               frame_err,
    output logic [CNT_W-1:0]   bit_count,
    output logic [ROWS*8-1:0]  seg_rows,
    output logic               row_err
);

    localparam logic [CNT_W-1:0] CNT_ONE   = 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W:0]   WIDTH_CNT = (CNT_W+1)'(WIDTH);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic rclk_lvl, rclk_rise, rclk_fall;
    logic srclr_lvl, srclr_rise, srclr_fall;
    logic serial_lvl, serial_rise, serial_fall;

    link_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(sclk_in),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );
    link_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_rclk (
        .clk(clk), .rst(rst), .din(rclk_in),
        .level(rclk_lvl), .rise(rclk_rise), .fall(rclk_fall)
    );
    link_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_srclr (
        .clk(clk), .rst(rst), .din(srclr_n_in),
        .level(srclr_lvl), .rise(srclr_rise), .fall(srclr_fall)
    );
    // Serial data goes through the same depth so it lines up with the sclk fall.
    link_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_serial (
        .clk(clk), .rst(rst), .din(serial_in),
        .level(serial_lvl), .rise(serial_rise), .fall(serial_fall)
    );

    logic unused_edges;
    assign unused_edges = ^{sclk_lvl, sclk_rise, rclk_lvl, rclk_fall,
                            srclr_rise, srclr_fall, serial_rise, serial_fall};

    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  word_q;
    logic              word_valid_q;
    logic              frame_err_q;
    logic [ROWS*8-1:0] rows_q;
    logic              row_err_q;
    logic              short_frame;

    logic [7:0] sel, seg;
    logic [3:0] zi;

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (!srclr_lvl) begin
            shreg_d = '0;
            cnt_d   = '0;
        end else if (sclk_fall) begin
            shreg_d = {shreg_q[WIDTH-2:0], serial_lvl};
            cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        end
        short_frame = ({1'b0, cnt_d} < WIDTH_CNT);
    end

    assign sel = word_q[SEL_MSB:SEL_LSB];
    assign seg = word_q[SEG_MSB:SEG_LSB];
    assign zi  = zero_index(sel);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q      <= '0;
            cnt_q        <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            rows_q       <= '0;
            row_err_q    <= 1'b0;
        end else begin
            shreg_q      <= shreg_d;
            cnt_q        <= rclk_rise ? '0 : cnt_d;
            word_valid_q <= rclk_rise;
            frame_err_q  <= rclk_rise & short_frame;
            if (rclk_rise) begin
                word_q <= shreg_d;
            end
            row_err_q <= 1'b0;
            if (word_valid_q) begin
                if (sel == 8'h00) begin
                    rows_q <= {ROWS{seg}};
                end else if (zi[3]) begin
                    rows_q[{zi[2:0], 3'b000} +: 8] <= seg;
                end else begin
                    row_err_q <= 1'b1;
                end
            end
        end
    end

    assign word       = word_q;
    assign word_valid = word_valid_q;
    assign frame_err  = frame_err_q;
    assign bit_count  = cnt_q;
    assign seg_rows   = rows_q;
    assign row_err    = row_err_q;

endmodule

// File: tb/tb_shift_link_rx.sv
// Directed bench for shift_link_rx: drives link frames and checks latched words and row image.
module tb_shift_link_rx;

    localparam int PH = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk_in, rclk_in, srclr_n_in, serial_in;
    logic [15:0] word;
    logic        word_valid, frame_err, row_err;
    logic [4:0]  bit_count;
    logic [63:0] seg_rows;

    int checks = 0;
    int errors = 0;

    shift_link_rx dut (
        .clk(clk), .rst(rst),
        .sclk_in(sclk_in), .rclk_in(rclk_in),
        .srclr_n_in(srclr_n_in), .serial_in(serial_in),
        .word(word), .word_valid(word_valid), .frame_err(frame_err),
        .bit_count(bit_count), .seg_rows(seg_rows), .row_err(row_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        serial_in = b;
        sclk_in   = 1'b1;
        repeat (PH) @(negedge clk);
        sclk_in = 1'b0;
        repeat (PH) @(negedge clk);
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic do_latch(input string tag, input logic fall_too, input logic [15:0] ew,
                            input logic efe, input logic erer, input logic [63:0] erows);
        int          lat;
        logic        seen;
        logic [15:0] w;
        logic        fe;
        seen = 1'b0; lat = 0; w = '0; fe = 1'b0;
        @(negedge clk);
        rclk_in = 1'b1;
        if (fall_too) sclk_in = 1'b0;
        for (int i = 1; i <= 10 && !seen; i++) begin
            @(negedge clk);
            if (word_valid) begin
                seen = 1'b1; lat = i; w = word; fe = frame_err;
            end
        end
        chk({tag, "_seen"}, seen, 1'b1);
        chk({tag, "_latency"}, lat, 3);
        chk({tag, "_word"}, w, ew);
        chk({tag, "_frame_err"}, fe, efe);
        @(negedge clk);
        chk({tag, "_valid_pulse"}, word_valid, 1'b0);
        chk({tag, "_row_err"}, row_err, erer);
        chk({tag, "_rows"}, seg_rows, erows);
        chk({tag, "_cnt_after"}, bit_count, 5'd0);
        @(negedge clk);
        chk({tag, "_row_err_pulse"}, row_err, 1'b0);
        repeat (PH) @(negedge clk);
        rclk_in = 1'b0;
        repeat (PH) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; sclk_in = 1'b0; rclk_in = 1'b0; srclr_n_in = 1'b1; serial_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_word", word, 16'h0);
        chk("rst_valid", word_valid, 1'b0);
        chk("rst_ferr", frame_err, 1'b0);
        chk("rst_cnt", bit_count, 5'd0);
        chk("rst_rows", seg_rows, 64'h0);
        chk("rst_rerr", row_err, 1'b0);
        rst = 1'b0;
        repeat (PH) @(negedge clk);

        // 1: single-row select
        send_bits(32'hFE5A, 16);
        chk("t1_cnt", bit_count, 5'd16);
        do_latch("t1", 1'b0, 16'hFE5A, 1'b0, 1'b0, 64'h0000_0000_0000_005A);

        // 2: broadcast
        send_bits(32'h00F0, 16);
        do_latch("t2", 1'b0, 16'h00F0, 1'b0, 1'b0, 64'hF0F0_F0F0_F0F0_F0F0);

        // 3: two zero select bits
        send_bits(32'hFC33, 16);
        do_latch("t3", 1'b0, 16'hFC33, 1'b0, 1'b1, 64'hF0F0_F0F0_F0F0_F0F0);

        // 4: short frame ({FC33[5:0], 10'h000} = CC00, invalid select), then 17-bit frame
        send_bits(32'h000, 10);
        chk("t4_cnt10", bit_count, 5'd10);
        do_latch("t4a", 1'b0, 16'hCC00, 1'b1, 1'b1, 64'hF0F0_F0F0_F0F0_F0F0);
        send_bits(32'h1_7F01, 17);
        chk("t4_cnt17", bit_count, 5'd17);
        do_latch("t4b", 1'b0, 16'h7F01, 1'b0, 1'b0, 64'h01F0_F0F0_F0F0_F0F0);

        // 5: clear after partial frame, then simultaneous sclk fall / rclk rise
        send_bits(32'hAA, 8);
        chk("t5_cnt8", bit_count, 5'd8);
        @(negedge clk);
        srclr_n_in = 1'b0;
        repeat (10) @(negedge clk);
        chk("t5_cnt_clr", bit_count, 5'd0);
        srclr_n_in = 1'b1;
        repeat (PH) @(negedge clk);
        do_latch("t5a", 1'b0, 16'h0000, 1'b1, 1'b0, 64'h0);
        send_bits(32'h7DA1, 15);
        @(negedge clk);
        serial_in = 1'b0;
        sclk_in   = 1'b1;
        repeat (PH) @(negedge clk);
        do_latch("t5b", 1'b1, 16'hFB42, 1'b0, 1'b0, 64'h0000_0000_0042_0000);

        // 6: reset mid-frame, then a clean frame
        send_bits(32'hFF, 8);
        chk("t6_cnt8", bit_count, 5'd8);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_word", word, 16'h0);
        chk("t6_rst_rows", seg_rows, 64'h0);
        chk("t6_rst_cnt", bit_count, 5'd0);
        chk("t6_rst_ferr", frame_err, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (PH) @(negedge clk);
        send_bits(32'hBF81, 16);
        chk("t6_cnt16", bit_count, 5'd16);
        do_latch("t6", 1'b0, 16'hBF81, 1'b0, 1'b0, 64'h0081_0000_0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
